bp_me_mem_stream_bridge: RTL and testbench
==========================================

# bp_me_mem_stream_bridge

- Sits directly downstream of the L2 cache slice's memory-side port.
- Accepts full-width memory commands and serializes them into a narrow, beat-oriented off-chip link as header beats followed by data beats.
- Deserializes returning link beats into full-width memory responses for the slice.
- Command and response directions are independent; each has one FSM.

## Interface
Parameters:
- bp_params_p, e_bp_inv_cfg: processor config; supplies paddr_width_p, cce_block_width_p and the mem message header layout.
- stream_width_p, 64: link beat width in bits; must divide cce_block_width_p.
- max_outstanding_p, 4: credit limit; used only with BP_ME_STREAM_CREDIT_EN.

Derived values:
- H = ceil(header_width / stream_width_p): number of header beats.
- D(size) = max(1, (8 << size) / stream_width_p): number of data beats, where the message carries 1 << size bytes.

Ports (reset is synchronous and active-low):
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous active-low reset
- mem_cmd_i  in  cce_mem_msg_width_lp  command (header plus block data)
- mem_cmd_v_i  in  1  command valid
- mem_cmd_yumi_o  out  1  command consumed this cycle
- mem_resp_o  out  cce_mem_msg_width_lp  response
- mem_resp_v_o  out  1  response valid
- mem_resp_ready_i  in  1  slice can accept a response
- link_data_o  out  stream_width_p  outgoing beat
- link_v_o  out  1  outgoing beat valid
- link_ready_i  in  1  link accepts beat
- link_data_i  in  stream_width_p  incoming beat
- link_v_i  in  1  incoming beat valid
- link_ready_o  out  1  bridge accepts beat

## Operation
Data-bearing messages:
- Command: e_cce_mem_wr, e_cce_mem_uc_wr.
- Response: e_cce_mem_rd, e_cce_mem_uc_rd.
- All other types send header beats only.

Command FSM (e_cmd_idle, e_cmd_hdr, e_cmd_data):
- e_cmd_idle:
  - mem_cmd_yumi_o = mem_cmd_v_i (and credit available when the macro is defined).
  - On yumi, latch the entire message, clear the beat counter, and go to e_cmd_hdr.
- e_cmd_hdr: drive header beats, least-significant first; the top beat is zero-padded.
  - After beat H-1 is accepted, go to e_cmd_data if the message carries data, else e_cmd_idle.
- e_cmd_data: drive data beats 0..D-1 from the low bits of the block.
  - After the last beat is accepted, go to e_cmd_idle.
- A beat is accepted when link_v_o & link_ready_i; the beat counter advances only on accept.
- link_data_o is held stable while link_v_o is high and link_ready_i is low.

Response FSM (e_resp_hdr, e_resp_data, e_resp_out):
- e_resp_hdr: link_ready_o = 1; shift in H beats.
  - After the last header beat, decode msg_type and size, and clear the data register.
  - Go to e_resp_data if the response carries data, else e_resp_out.
- e_resp_data: link_ready_o = 1; beat i fills block bits [i*stream_width_p +: stream_width_p].
  - Bits not written remain zero.
  - After D beats, go to e_resp_out.
- e_resp_out: link_ready_o = 0; mem_resp_v_o = 1.
  - On mem_resp_ready_i, go to e_resp_hdr.

Boundary behaviour:
- Reset mid-message: both FSMs return to their initial state; any partial message is dropped; counters and credits clear.
- Size encodings with D > block/stream are clamped to block/stream.

## Timing
Reset values:
- mem_cmd_yumi_o=0, mem_resp_v_o=0, link_v_o=0, link_ready_o=0, link_data_o=0, mem_resp_o=0.
- After reset: command FSM in e_cmd_idle, response FSM in e_resp_hdr.

Command path:
- yumi in cycle 0; first beat (link_v_o registered) in cycle 1.
- With link_ready_i held high, the last beat is in cycle H+D.
- Earliest next yumi is cycle H+D+1 (one idle bubble per message).

Response path:
- Last beat accepted in cycle N; mem_resp_v_o asserted in cycle N+1.
- The next link beat is accepted no earlier than the cycle after the mem_resp handshake.

Concurrency:
- The command and response paths never stall each other.

## Configuration
Macro: BP_ME_STREAM_CREDIT_EN.

Defined:
- An outstanding counter of width clog2(max_outstanding_p+1) increments on command yumi and decrements on the mem_resp handshake.
- An increment and decrement in the same cycle leave the counter unchanged.
- Yumi is suppressed while the count equals max_outstanding_p.

Undefined:
- No counter; commands are accepted whenever the command FSM is idle.

## Test plan
- Uncached write, size 3 (8 B), data 0xDEADBEEF_01234567, link ready always -> H header beats, then one beat 0xDEADBEEF_01234567; next yumi in cycle H+2.
- Cached write, 64 B, data bytes 0x00..0x3F, link_ready_i toggled every cycle -> 8 data beats, beat i = bytes 8i..8i+7; link_data_o stable across stalls; no beat lost or duplicated.
- Cached read command -> header beats only. Matching read response of H+8 beats -> mem_resp_o block equals the 8 beats concatenated; mem_resp_v_o rises the cycle after the last beat.
- Uncached read response, size 2 (4 B), with mem_resp_ready_i low for 5 cycles -> upper block bits zero; mem_resp_v_o held 5 cycles; link_ready_o=0 throughout the wait.
- reset_n_i pulled low at data beat 3 of a write -> next cycle all outputs are at reset values. A new command after release serializes from header beat 0.
- With BP_ME_STREAM_CREDIT_EN and max_outstanding_p=2: send 3 reads with no responses -> third yumi withheld. Return one response -> third command accepted the cycle after the mem_resp handshake.

Source files
------------

// File: rtl/bp_me_mem_stream_bridge.sv
// Bridge between the L2 slice memory port and a narrow beat-oriented link.
// Optional credit limiting is enabled by defining BP_ME_STREAM_CREDIT_EN.
module bp_me_mem_stream_bridge #(
  parameter int paddr_width_p     = 40,
  parameter int cce_block_width_p = 512,
  parameter int stream_width_p    = 64,
  parameter int max_outstanding_p = 4,
  localparam int msg_type_width_lp    = 4,
  localparam int msg_size_width_lp    = 3,
  localparam int msg_payload_width_lp = 32,
  localparam int header_width_lp      = msg_type_width_lp + msg_size_width_lp
                                        + paddr_width_p + msg_payload_width_lp,
  localparam int cce_mem_msg_width_lp = cce_block_width_p + header_width_lp
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_ready_i,
  output logic [stream_width_p-1:0]       link_data_o,
  output logic                            link_v_o,
  input  logic                            link_ready_i,
  input  logic [stream_width_p-1:0]       link_data_i,
  input  logic                            link_v_i,
  output logic                            link_ready_o
);

  localparam int hdr_beats_lp   = (header_width_lp + stream_width_p - 1) / stream_width_p;
  localparam int hdr_pad_w_lp   = hdr_beats_lp * stream_width_p;
  localparam int block_beats_lp = cce_block_width_p / stream_width_p;
  localparam int max_beats_lp   = (hdr_beats_lp > block_beats_lp) ? hdr_beats_lp : block_beats_lp;
  localparam int cnt_width_lp   = $clog2(max_beats_lp + 1);
  localparam int size_lsb_lp    = msg_type_width_lp;
  localparam logic [cnt_width_lp-1:0] hdr_last_lp = cnt_width_lp'(hdr_beats_lp - 1);

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_wb    = 4'd4,
    e_cce_mem_pre   = 4'd5
  } mem_msg_type_e;

  typedef enum logic [1:0] {e_cmd_idle, e_cmd_hdr, e_cmd_data} cmd_state_e;
  typedef enum logic [1:0] {e_resp_hdr, e_resp_data, e_resp_out} resp_state_e;

  // Beat count for a message of 1 << size bytes, clamped to one block.
  function automatic logic [cnt_width_lp-1:0] data_beats(input logic [msg_size_width_lp-1:0] size);
    int bits;
    int beats;
    bits  = 8 << size;
    beats = bits / stream_width_p;
    if (beats < 1) beats = 1;
    if (beats > block_beats_lp) beats = block_beats_lp;
    return cnt_width_lp'(beats);
  endfunction

  function automatic logic cmd_has_data(input logic [msg_type_width_lp-1:0] t);
    return (t == e_cce_mem_wr) || (t == e_cce_mem_uc_wr);
  endfunction

  function automatic logic resp_has_data(input logic [msg_type_width_lp-1:0] t);
    return (t == e_cce_mem_rd) || (t == e_cce_mem_uc_rd);
  endfunction

  logic credit_avail;

  // Command serializer
  cmd_state_e                 cmd_state_r, cmd_state_n;
  logic [cnt_width_lp-1:0]    cmd_cnt_r, cmd_cnt_n;
  logic [cnt_width_lp-1:0]    cmd_last_r;
  logic                       cmd_data_r_v;
  logic [hdr_pad_w_lp-1:0]    cmd_hdr_r;
  logic [cce_block_width_p-1:0] cmd_data_r;
  logic                       cmd_yumi;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cmd_state_r <= e_cmd_idle;
      cmd_cnt_r   <= '0;
    end else begin
      cmd_state_r <= cmd_state_n;
      cmd_cnt_r   <= cmd_cnt_n;
    end
  end

  always_comb begin
    cmd_state_n = cmd_state_r;
    cmd_cnt_n   = cmd_cnt_r;
    cmd_yumi    = 1'b0;
    case (cmd_state_r)
      e_cmd_idle: begin
        cmd_yumi = reset_n_i & mem_cmd_v_i & credit_avail;
        if (cmd_yumi) begin
          cmd_state_n = e_cmd_hdr;
          cmd_cnt_n   = '0;
        end
      end
      e_cmd_hdr: begin
        if (link_ready_i) begin
          if (cmd_cnt_r == hdr_last_lp) begin
            cmd_cnt_n   = '0;
            cmd_state_n = cmd_data_r_v ? e_cmd_data : e_cmd_idle;
          end else begin
            cmd_cnt_n = cmd_cnt_r + 1'b1;
          end
        end
      end
      e_cmd_data: begin
        if (link_ready_i) begin
          if (cmd_cnt_r == cmd_last_r) begin
            cmd_cnt_n   = '0;
            cmd_state_n = e_cmd_idle;
          end else begin
            cmd_cnt_n = cmd_cnt_r + 1'b1;
          end
        end
      end
      default: cmd_state_n = e_cmd_idle;
    endcase
  end

  // Outgoing beats are always the low slice of a right-shifting copy.
  always_ff @(posedge clk_i) begin
    if (cmd_yumi) begin
      cmd_hdr_r    <= hdr_pad_w_lp'(mem_cmd_i[header_width_lp-1:0]);
      cmd_data_r   <= mem_cmd_i[cce_mem_msg_width_lp-1:header_width_lp];
      cmd_data_r_v <= cmd_has_data(mem_cmd_i[msg_type_width_lp-1:0]);
      cmd_last_r   <= data_beats(mem_cmd_i[size_lsb_lp +: msg_size_width_lp]) - 1'b1;
    end else if (link_ready_i) begin
      if (cmd_state_r == e_cmd_hdr)  cmd_hdr_r  <= cmd_hdr_r >> stream_width_p;
      if (cmd_state_r == e_cmd_data) cmd_data_r <= cmd_data_r >> stream_width_p;
    end
  end

  assign mem_cmd_yumi_o = cmd_yumi;
  assign link_v_o       = (cmd_state_r != e_cmd_idle);
  assign link_data_o    = (cmd_state_r == e_cmd_hdr)  ? cmd_hdr_r[stream_width_p-1:0]
                        : (cmd_state_r == e_cmd_data) ? cmd_data_r[stream_width_p-1:0]
                        : '0;

  // Response deserializer
  resp_state_e                  resp_state_r, resp_state_n;
  logic [cnt_width_lp-1:0]      resp_cnt_r, resp_cnt_n;
  logic [cnt_width_lp-1:0]      resp_last_r;
  logic [hdr_pad_w_lp-1:0]      resp_hdr_r;
  logic [hdr_pad_w_lp+stream_width_p-1:0] resp_hdr_cat;
  logic [hdr_pad_w_lp-1:0]      resp_hdr_shift;
  logic [cce_block_width_p-1:0] resp_data_r;
  logic                         resp_accept;

  assign resp_hdr_cat   = {link_data_i, resp_hdr_r};
  assign resp_hdr_shift = resp_hdr_cat[hdr_pad_w_lp+stream_width_p-1:stream_width_p];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      resp_state_r <= e_resp_hdr;
      resp_cnt_r   <= '0;
    end else begin
      resp_state_r <= resp_state_n;
      resp_cnt_r   <= resp_cnt_n;
    end
  end

  always_comb begin
    resp_state_n = resp_state_r;
    resp_cnt_n   = resp_cnt_r;
    link_ready_o = 1'b0;
    mem_resp_v_o = 1'b0;
    case (resp_state_r)
      e_resp_hdr: begin
        link_ready_o = reset_n_i;
        if (link_v_i & reset_n_i) begin
          if (resp_cnt_r == hdr_last_lp) begin
            resp_cnt_n   = '0;
            resp_state_n = resp_has_data(resp_hdr_shift[msg_type_width_lp-1:0])
                           ? e_resp_data : e_resp_out;
          end else begin
            resp_cnt_n = resp_cnt_r + 1'b1;
          end
        end
      end
      e_resp_data: begin
        link_ready_o = reset_n_i;
        if (link_v_i & reset_n_i) begin
          if (resp_cnt_r == resp_last_r) begin
            resp_cnt_n   = '0;
            resp_state_n = e_resp_out;
          end else begin
            resp_cnt_n = resp_cnt_r + 1'b1;
          end
        end
      end
      e_resp_out: begin
        mem_resp_v_o = 1'b1;
        if (mem_resp_ready_i) resp_state_n = e_resp_hdr;
      end
      default: resp_state_n = e_resp_hdr;
    endcase
  end

  assign resp_accept = link_v_i & link_ready_o;

  // Short responses leave the untouched upper block bits at zero.
  always_ff @(posedge clk_i) begin
    if (resp_accept) begin
      if (resp_state_r == e_resp_hdr) begin
        resp_hdr_r <= resp_hdr_shift;
        if (resp_cnt_r == hdr_last_lp) begin
          resp_data_r <= '0;
          resp_last_r <= data_beats(resp_hdr_shift[size_lsb_lp +: msg_size_width_lp]) - 1'b1;
        end
      end else begin
        for (int i = 0; i < block_beats_lp; i++) begin
          if (resp_cnt_r == cnt_width_lp'(i))
            resp_data_r[i*stream_width_p +: stream_width_p] <= link_data_i;
        end
      end
    end
  end

  assign mem_resp_o = mem_resp_v_o ? {resp_data_r, resp_hdr_r[header_width_lp-1:0]} : '0;

`ifdef BP_ME_STREAM_CREDIT_EN
  localparam int credit_width_lp = $clog2(max_outstanding_p + 1);
  logic [credit_width_lp-1:0] outstanding_r;
  logic                       credit_dec;

  assign credit_dec = mem_resp_v_o & mem_resp_ready_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      outstanding_r <= '0;
    end else begin
      case ({cmd_yumi, credit_dec})
        2'b10:   outstanding_r <= outstanding_r + 1'b1;
        2'b01:   outstanding_r <= outstanding_r - 1'b1;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  assign credit_avail = (outstanding_r != credit_width_lp'(max_outstanding_p));
`else
  assign credit_avail = (max_outstanding_p > 0);
`endif

endmodule

// File: tb/tb_bp_me_mem_stream_bridge.sv
// Directed scoreboard bench for bp_me_mem_stream_bridge (64-bit link, 512-bit block).
module tb_bp_me_mem_stream_bridge;

  localparam int S  = 64;
  localparam int H  = 2;
  localparam int HW = 79;
  localparam int B  = 512;
  localparam int MW = B + HW;
`ifdef BP_ME_STREAM_CREDIT_EN
  localparam int MAXO = 2;
`else
  localparam int MAXO = 4;
`endif

  logic          clk;
  logic          reset_n;
  logic [MW-1:0] mem_cmd;
  logic          mem_cmd_v;
  logic          mem_cmd_yumi;
  logic [MW-1:0] mem_resp;
  logic          mem_resp_v;
  logic          mem_resp_ready;
  logic [S-1:0]  link_data_out;
  logic          link_v_out;
  logic          link_ready_in;
  logic [S-1:0]  link_data_in;
  logic          link_v_in;
  logic          link_ready_out;

  bp_me_mem_stream_bridge #(
    .paddr_width_p(40), .cce_block_width_p(B), .stream_width_p(S), .max_outstanding_p(MAXO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .mem_cmd_i(mem_cmd), .mem_cmd_v_i(mem_cmd_v), .mem_cmd_yumi_o(mem_cmd_yumi),
    .mem_resp_o(mem_resp), .mem_resp_v_o(mem_resp_v), .mem_resp_ready_i(mem_resp_ready),
    .link_data_o(link_data_out), .link_v_o(link_v_out), .link_ready_i(link_ready_in),
    .link_data_i(link_data_in), .link_v_i(link_v_in), .link_ready_o(link_ready_out)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [S-1:0]  cmd_q[$];
  logic [MW-1:0] resp_q[$];
  logic [S-1:0]  held;
  bit            stall_pending = 0;
  bit            lr_toggle = 0;
  int            yumi_cyc;
  logic          lv_at_yumi;
  logic          rv_at_acc;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (lr_toggle) link_ready_in = ~link_ready_in;
    else link_ready_in = 1'b1;
  end

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for both directions.
  initial forever begin
    @(negedge clk);
    if (stall_pending && link_v_out) check("link_hold", MW'(link_data_out), MW'(held));
    stall_pending = link_v_out && !link_ready_in;
    held = link_data_out;
    if (link_v_out && link_ready_in) begin
      if (cmd_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL link_beat: got %h with no beat expected", link_data_out);
      end else check("link_beat", MW'(link_data_out), MW'(cmd_q.pop_front()));
    end
    if (mem_resp_v && mem_resp_ready) begin
      if (resp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL mem_resp: got %h with no response expected", mem_resp);
      end else check("mem_resp", mem_resp, resp_q.pop_front());
    end
  end

  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] sz,
                                           input logic [39:0] a, input logic [31:0] p);
    return {p, a, sz, t};
  endfunction

  task automatic push_cmd(input logic [HW-1:0] h, input logic [B-1:0] d, input int nd);
    logic [H*S-1:0] hp;
    hp = {{(H*S-HW){1'b0}}, h};
    for (int i = 0; i < H; i++) cmd_q.push_back(hp[i*S +: S]);
    for (int i = 0; i < nd; i++) cmd_q.push_back(d[i*S +: S]);
  endtask

  // Called just after a rising edge; returns just after the edge following yumi.
  task automatic send_cmd(input logic [HW-1:0] h, input logic [B-1:0] d);
    bit got;
    got = 0;
    mem_cmd = {d, h};
    mem_cmd_v = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (mem_cmd_yumi) begin
        got = 1; yumi_cyc = cyc; lv_at_yumi = link_v_out;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL yumi_timeout: got no yumi, required yumi within 64 cycles");
    end
    @(posedge clk); #1;
    mem_cmd_v = 1'b0;
  endtask

  task automatic send_beat(input logic [S-1:0] b);
    bit got;
    got = 0;
    link_data_in = b;
    link_v_in = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (link_ready_out) begin
        got = 1; rv_at_acc = mem_resp_v;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL beat_timeout: got link_ready_o low, required acceptance within 64 cycles");
    end
    @(posedge clk); #1;
    link_v_in = 1'b0;
  endtask

  task automatic send_resp(input logic [HW-1:0] h, input logic [B-1:0] d, input int nd);
    logic [H*S-1:0] hp;
    hp = {{(H*S-HW){1'b0}}, h};
    for (int i = 0; i < H; i++) send_beat(hp[i*S +: S]);
    for (int i = 0; i < nd; i++) send_beat(d[i*S +: S]);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (cmd_q.size() != 0 || resp_q.size() != 0); k++) @(negedge clk);
    check("drain_cmd_q", MW'(cmd_q.size()), MW'(0));
    check("drain_resp_q", MW'(resp_q.size()), MW'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_yumi"}, MW'(mem_cmd_yumi), MW'(0));
    check({tag, "_resp_v"}, MW'(mem_resp_v), MW'(0));
    check({tag, "_link_v"}, MW'(link_v_out), MW'(0));
    check({tag, "_link_ready"}, MW'(link_ready_out), MW'(0));
    check({tag, "_link_data"}, MW'(link_data_out), MW'(0));
    check({tag, "_resp"}, mem_resp, MW'(0));
  endtask

  initial begin
    logic [HW-1:0] h;
    logic [B-1:0]  d;
    int            y1;
    int            good;

    reset_n = 1'b0;
    mem_cmd = '0;
    mem_cmd_v = 1'b1;
    mem_resp_ready = 1'b1;
    link_ready_in = 1'b1;
    link_data_in = '0;
    link_v_in = 1'b0;

    // Reset values, with a command already offered.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    mem_cmd_v = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_link_ready", MW'(link_ready_out), MW'(1));
    check("idle_link_v", MW'(link_v_out), MW'(0));
    @(posedge clk); #1;

    // Uncached write, 8 bytes, back-to-back with a second one.
    h = mk_hdr(4'd3, 3'd3, 40'h00_8000_1000, 32'h0000_00A5);
    d = '0; d[63:0] = 64'hDEADBEEF_01234567;
    push_cmd(h, d, 1);
    send_cmd(h, d);
    y1 = yumi_cyc;
    check("yumi_link_v_low", MW'(lv_at_yumi), MW'(0));
    @(negedge clk);
    check("first_beat_v", MW'(link_v_out), MW'(1));
    @(posedge clk); #1;
    h = mk_hdr(4'd3, 3'd3, 40'h00_8000_1040, 32'h0000_005A);
    d = '0; d[63:0] = 64'h0F0E0D0C_0B0A0908;
    push_cmd(h, d, 1);
    send_cmd(h, d);
    check("next_yumi_gap", MW'(yumi_cyc - y1), MW'(H + 2));
    drain();
    do_reset();

    // Cached write, 64 bytes 0x00..0x3F, link_ready toggling.
    lr_toggle = 1;
    h = mk_hdr(4'd1, 3'd6, 40'h00_0000_2000, 32'h0000_0001);
    for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'(k);
    push_cmd(h, d, 8);
    send_cmd(h, d);
    drain();
    lr_toggle = 0;

    // Cached read: header beats only, then a full-block response.
    h = mk_hdr(4'd0, 3'd6, 40'h00_0000_3000, 32'h0000_0002);
    push_cmd(h, '0, 0);
    send_cmd(h, '0);
    drain();
    for (int i = 0; i < 8; i++) d[64*i +: 64] = {32'hC0DE_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
    resp_q.push_back({d, h});
    send_resp(h, d, 8);
    check("resp_v_before", MW'(rv_at_acc), MW'(0));
    @(negedge clk);
    check("resp_v_after_last", MW'(mem_resp_v), MW'(1));
    @(posedge clk); #1;
    drain();

    // Uncached read, 4 bytes, slice holds off for 5 cycles.
    mem_resp_ready = 1'b0;
    h = mk_hdr(4'd2, 3'd2, 40'h00_0000_4004, 32'h0000_0003);
    d = '0; d[63:0] = 64'h01234567_89ABCDEF;
    resp_q.push_back({d, h});
    send_resp(h, d, 1);
    check("uc_resp_v_before", MW'(rv_at_acc), MW'(0));
    good = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_resp_v && !link_ready_out) good++;
      @(posedge clk); #1;
    end
    check("resp_wait_hold", MW'(good), MW'(5));
    mem_resp_ready = 1'b1;
    drain();

    // Reset while data beat 3 of a cached write is on the link.
    h = mk_hdr(4'd1, 3'd6, 40'h00_0000_5000, 32'h0000_0004);
    for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'(8'hA0 + k);
    push_cmd(h, d, 4);
    send_cmd(h, d);
    repeat (5) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midreset");
    check("midreset_beats_left", MW'(cmd_q.size()), MW'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    h = mk_hdr(4'd3, 3'd3, 40'h00_0000_6000, 32'h0000_0005);
    d = '0; d[63:0] = 64'h55AA_33CC_0FF0_1234;
    push_cmd(h, d, 1);
    send_cmd(h, d);
    drain();

`ifdef BP_ME_STREAM_CREDIT_EN
    // Credit limit of 2: third command waits for one response.
    do_reset();
    h = mk_hdr(4'd0, 3'd6, 40'h00_0000_7000, 32'h0000_0006);
    push_cmd(h, '0, 0);
    send_cmd(h, '0);
    h = mk_hdr(4'd0, 3'd6, 40'h00_0000_7040, 32'h0000_0007);
    push_cmd(h, '0, 0);
    send_cmd(h, '0);
    h = mk_hdr(4'd0, 3'd6, 40'h00_0000_7080, 32'h0000_0008);
    push_cmd(h, '0, 0);
    mem_cmd = {{B{1'b0}}, h};
    mem_cmd_v = 1'b1;
    good = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_cmd_yumi) good++;
      @(posedge clk); #1;
    end
    check("credit_withheld", MW'(good), MW'(0));
    h = mk_hdr(4'd1, 3'd6, 40'h00_0000_7000, 32'h0000_0006);
    resp_q.push_back({{B{1'b0}}, h});
    send_resp(h, '0, 0);
    @(negedge clk);
    check("credit_hs_v", MW'(mem_resp_v), MW'(1));
    check("credit_hs_yumi", MW'(mem_cmd_yumi), MW'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("credit_yumi_after_hs", MW'(mem_cmd_yumi), MW'(1));
    @(posedge clk); #1;
    mem_cmd_v = 1'b0;
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
